// File: rtl/fdtd_probe_pkg.sv
// Shared types and default sizing for the FDTD field probe capture block.
package fdtd_probe_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned IDX_WIDTH_DEF  = 15;
  localparam int unsigned STEP_WIDTH_DEF = 8;
  localparam int unsigned DEPTH_DEF      = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    HOLD  = 2'd2
  } probe_state_t;

  // Capture FIFO entry layout at default widths: step in the upper bits.
  typedef struct packed {
    logic [STEP_WIDTH_DEF-1:0] step;
    logic [DATA_WIDTH_DEF-1:0] data;
  } probe_entry_t;

endpackage

// File: rtl/fdtd_probe_sfifo.sv
// Synchronous FIFO with flush; head is presented from registered storage.
module fdtd_probe_sfifo #(
  parameter int unsigned WIDTH = 40,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata_c,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             drop_c
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             full_q;
  logic             empty_q;
  logic             do_push;
  logic             do_pop;

  // A pop frees a slot in the same cycle, so push-while-full succeeds with a pop.
  always_comb begin
    do_pop  = pop & ~empty_q;
    do_push = push & (~full_q | do_pop);
    drop_c  = push & ~do_push;
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      empty_q <= (count_d == '0);
      full_q  <= (count_d == CW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr && !rst) mem[wr_ptr_q] <= wdata;
  end

  assign rdata_c = empty_q ? '0 : mem[rd_ptr_q];
  assign count   = count_q;
  assign full    = full_q;
  assign empty   = empty_q;

endmodule

// File: rtl/fdtd_probe_capture.sv
// Captures one Ez sample per FDTD time step at a probed cell into a FIFO.
module fdtd_probe_capture
  import fdtd_probe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned IDX_WIDTH  = IDX_WIDTH_DEF,
  parameter int unsigned STEP_WIDTH = STEP_WIDTH_DEF,
  parameter int unsigned DEPTH      = DEPTH_DEF,
  localparam int unsigned CW        = $clog2(DEPTH) + 1
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic                  clr_i,
  input  logic [STEP_WIDTH-1:0] num_steps_i,
  input  logic [IDX_WIDTH-1:0]  sample_point_i,
  input  logic [CW-1:0]         thresh_i,
  input  logic                  ez_valid_i,
  input  logic [IDX_WIDTH-1:0]  ez_idx_i,
  input  logic [DATA_WIDTH-1:0] ez_data_i,
  input  logic                  step_end_i,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic [STEP_WIDTH-1:0] rd_step_o,
  output logic [CW-1:0]         count_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  overflow_o,
  output logic                  miss_o,
  output logic                  int_o
);

  localparam int unsigned EW = STEP_WIDTH + DATA_WIDTH;

  typedef struct packed {
    logic [STEP_WIDTH-1:0] step;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  probe_state_t          state_q, state_d;
  logic [STEP_WIDTH-1:0] step_q, step_d;
  logic [STEP_WIDTH-1:0] num_q, num_d;
  logic                  done_q, done_d;
  logic                  miss_q, miss_d;
  logic                  busy_q;
  logic                  ovf_q;
  logic                  int_q;
  logic                  capture_c;
  entry_t                wr_entry;
  entry_t                head_c;
  logic                  drop_c;

  // Abort outranks a capture in the same cycle.
  assign capture_c = (state_q == ARMED) && ez_valid_i &&
                     (ez_idx_i == sample_point_i) && !abort_i;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= IDLE;
      step_q  <= '0;
      num_q   <= '0;
      done_q  <= 1'b0;
      miss_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      num_q   <= num_d;
      done_q  <= done_d;
      miss_q  <= miss_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  // num_q of zero makes num_q-1 all ones, giving a 2^STEP_WIDTH step run.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    num_d   = num_q;
    done_d  = 1'b0;
    miss_d  = miss_q;
    if (abort_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_d = ARMED;
            step_d  = '0;
            num_d   = num_steps_i;
          end
        end
        ARMED, HOLD: begin
          if (capture_c) state_d = HOLD;
          if (step_end_i) begin
            if (state_q == ARMED && !capture_c) miss_d = 1'b1;
            if (step_q == num_q - STEP_WIDTH'(1)) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              step_d  = step_q + STEP_WIDTH'(1);
              state_d = ARMED;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if (clr_i) miss_d = 1'b0;
  end

  always_comb begin
    wr_entry.step = step_q;
    wr_entry.data = ez_data_i;
  end

  fdtd_probe_sfifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_sfifo (
    .clk     (ACLK),
    .rst     (ARESET),
    .clr     (clr_i),
    .push    (capture_c),
    .pop     (rd_en_i),
    .wdata   (wr_entry),
    .rdata_c (head_c),
    .count   (count_o),
    .full    (full_o),
    .empty   (empty_o),
    .drop_c  (drop_c)
  );

  // Sticky overflow and the threshold/done interrupt.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      ovf_q <= 1'b0;
      int_q <= 1'b0;
    end else begin
      if (clr_i)       ovf_q <= 1'b0;
      else if (drop_c) ovf_q <= 1'b1;
      int_q <= ((thresh_i != '0) && (count_o >= thresh_i)) || done_q;
    end
  end

  assign rd_data_o  = head_c.data;
  assign rd_step_o  = head_c.step;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign overflow_o = ovf_q;
  assign miss_o     = miss_q;
  assign int_o      = int_q;

endmodule
